// File: rtl/seg_display_scan.sv
// Score display driver: binary-to-BCD (shift-add-3) or hex capture, latched into a
// display register and time-multiplexed onto NUM_DIGITS active-low 7-segment digits.
module seg_display_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCORE_W     = 12,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [SCORE_W-1:0]    value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic                  busy,
  output logic                  ovf,
  output logic [6:0]            seven_seg,
  output logic [NUM_DIGITS-1:0] seg_select
);

  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  // BCD register holds every decimal digit SCORE_W can produce, never fewer than displayed
  localparam int BCD_N  = (dec_digits(SCORE_W) > NUM_DIGITS) ? dec_digits(SCORE_W) : NUM_DIGITS;
  localparam int BCD_W  = 4 * BCD_N;
  localparam int DISP_W = 4 * NUM_DIGITS;
  localparam int CNT_W  = $clog2(SCORE_W) + 1;
  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_busy;
  logic                  w_accept;
  logic                  w_commit;

  logic [SCORE_W-1:0]    r_shift;
  logic                  r_hex;
  logic [CNT_W-1:0]      r_cnt;
  logic [BCD_W:0]        r_bcd;
  logic [BCD_W-1:0]      w_bcd_adj;
  logic [DISP_W-1:0]     w_hex_disp;
  logic                  w_bcd_ovf;

  logic [DISP_W-1:0]     r_disp;
  logic                  r_disp_hex;
  logic                  r_ovf;

  logic [PRE_W-1:0]      r_pre;
  logic [IDX_W-1:0]      r_idx;

  logic [3:0]            w_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_zero_from;
  logic                  w_blank;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_sel;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_accept     = 1'b1;
          w_state_next = hex_mode ? S_COMMIT : S_CONVERT;
        end
      end
      S_CONVERT: begin
        w_busy = 1'b1;
        if (r_cnt == '0) w_state_next = S_COMMIT;
      end
      S_COMMIT: begin
        w_busy       = 1'b1;
        w_commit     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < BCD_N; gi++) begin : g_bcd_adj
    assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? r_bcd[4*gi +: 4] + 4'd3
                                                              : r_bcd[4*gi +: 4];
  end

  // Any nonzero BCD bit above the displayed digits (including the guard bit) means out of range
  assign w_bcd_ovf = |r_bcd[BCD_W:DISP_W];

  if (SCORE_W >= DISP_W) begin : g_hex_trunc
    assign w_hex_disp = r_shift[DISP_W-1:0];
  end else begin : g_hex_ext
    assign w_hex_disp = {{(DISP_W - SCORE_W){1'b0}}, r_shift};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_shift    <= '0;
      r_hex      <= 1'b0;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_disp     <= '0;
      r_disp_hex <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift <= value;
        r_hex   <= hex_mode;
        r_bcd   <= '0;
        r_cnt   <= CNT_W'(SCORE_W - 1);
      end
      if (r_state == S_CONVERT) begin
        r_bcd   <= {w_bcd_adj, r_shift[SCORE_W-1]};
        r_shift <= r_shift << 1;
        r_cnt   <= r_cnt - CNT_W'(1);
      end
      if (w_commit) begin
        r_disp_hex <= r_hex;
        if (r_hex) begin
          r_disp <= w_hex_disp;
          r_ovf  <= 1'b0;
        end else begin
          r_disp <= r_bcd[DISP_W-1:0];
          r_ovf  <= w_bcd_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_MAX) begin
      r_pre <= '0;
      r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // w_zero_from[i]: digits i and above are all zero
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
    assign w_digit[gi]     = r_disp[4*gi +: 4];
    assign w_zero_from[gi] = (r_disp[DISP_W-1:4*gi] == '0);
  end

  assign w_blank = blank_lz && !r_disp_hex && !r_ovf && (r_idx != '0) && w_zero_from[r_idx];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_seg <= 7'b1111111;
      r_sel <= '1;
    end else if (!enable) begin
      r_seg <= 7'b1111111;
      r_sel <= '1;
    end else begin
      r_sel <= ~(NUM_DIGITS'(1) << r_idx);
      if (r_ovf)        r_seg <= 7'b1111110;
      else if (w_blank) r_seg <= 7'b1111111;
      else              r_seg <= glyph(w_digit[r_idx]);
    end
  end

  assign busy       = w_busy;
  assign ovf        = r_ovf;
  assign seven_seg  = r_seg;
  assign seg_select = r_sel;

endmodule

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
- Parametrised successor to the two-digit score display driver.
- Takes a binary score of SCORE_W bits and converts it to decimal sequentially (shift-add-3, one bit per cycle); hex mode bypasses the conversion.
- Latches the result into a display register and time-multiplexes NUM_DIGITS active-low seven-segment digits.
- Adds leading-zero blanking, overflow indication, display enable and a load/busy handshake; sits between game score logic and board display pins.

Parameters:
- NUM_DIGITS, 4, digits driven; legal range 1..8.
- SCORE_W, 12, binary input width; legal range 1..27.
- REFRESH_DIV, 100000, clk cycles per digit slot; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- value  in  SCORE_W  binary value; sampled only on an accepted load.
- load  in  1  one-cycle request to capture value.
- hex_mode  in  1  1 = show hex nibbles; 0 = decimal. Sampled with load.
- blank_lz  in  1  1 = blank leading zero digits (decimal mode only).
- enable  in  1  0 = all digits off.
- busy  out  1  high while a conversion/commit is in progress.
- ovf  out  1  high while the displayed decimal value is out of range.
- seven_seg  out  7  segments {a,b,c,d,e,f,g}, active-low (0 = lit).
- seg_select  out  NUM_DIGITS  digit anodes, active-low one-hot; bit i = digit i, where digit 0 is least significant.

Behaviour:
- Reset (clr_n=0, takes effect immediately):
  - FSM = IDLE, busy=0, ovf=0, display register=0.
  - Scan index=0, prescaler=0.
  - seven_seg=7'b1111111, seg_select=all ones.
  - A reset mid-conversion aborts it; the display register stays 0.
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE: if load=1, capture value and hex_mode.
    - Decimal: go to CONVERT with a SCORE_W-cycle bit counter.
    - Hex: go straight to COMMIT.
  - CONVERT: each cycle, add 3 to every BCD nibble >=5, then shift in the next value MSB. After SCORE_W cycles, go to COMMIT.
  - COMMIT: write the display register, mode flag and ovf; return to IDLE.
  - busy=1 in CONVERT and COMMIT.
  - load while busy=1 is ignored; no queueing.
  - A load in the same cycle that COMMIT completes is also ignored; load is accepted only when busy=0.
- Latency, counted from the load cycle: display register updates at the edge SCORE_W+1 cycles later (decimal) or 1 cycle later (hex).
- Display register update is atomic; the old value is shown until COMMIT.
- Overflow (decimal only):
  - Condition: captured value > 10^NUM_DIGITS-1.
  - At COMMIT: ovf=1 and every digit shows '-' (7'b1111110).
  - The next in-range commit, or any hex commit, clears ovf.
- Hex digit i = value[4i+3:4i], zero-extended past SCORE_W. Hex mode never sets ovf and never blanks.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1. On wrap, the index advances 0..NUM_DIGITS-1 and wraps to 0.
  - Scan runs continuously, independent of FSM and enable.
  - With NUM_DIGITS=1 the index stays 0.
- Outputs are registered, reflecting index, display register and inputs of the previous cycle (1-cycle latency).
  - enable=0: seg_select=all ones, seven_seg=7'b1111111.
  - Otherwise seg_select[index]=0 and all other bits are 1.
- Leading-zero blanking: applies when decimal mode, blank_lz=1 and ovf=0.
  - A digit above the most significant nonzero digit outputs 7'b1111111; its anode stays selected.
  - Digit 0 is never blanked, so value 0 shows "0".
  - blank_lz is live, not latched.
- Glyphs, 0..F:
  - 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111.
  - 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.

Test Plan:
1. Pulse clr_n low mid-scan -> outputs immediately seven_seg=1111111, seg_select=4'b1111, busy=0, ovf=0. After release with enable=1, index 0 selected (seg_select=1110) and glyph 0 shown.
2. Defaults, REFRESH_DIV=4, decimal load value=137, blank_lz=1:
   - busy high 13 cycles; commit lands 13 cycles after load.
   - Scan shows digit0=0001111, digit1=0000110, digit2=1001111, digit3=1111111.
   - Each slot lasts 4 cycles.
3. hex_mode=1, value=12'hABC -> busy 1 cycle; digits C,B,A,0 = 0110001, 1100000, 0001000, 0000001; blank_lz=1 has no effect.
4. SCORE_W=14, value=10000 decimal -> ovf=1, all digits 1111110. A following load of 42 -> ovf=0, display 2,4,blank,blank.
5. Load 5 while busy from a prior load of 999 -> second load ignored, display 999. enable=0 -> seg_select=1111 with scan continuing; re-enable resumes at the current index.
6. Assert clr_n low during CONVERT -> busy drops asynchronously and the display shows 0. A load after release converts normally.
